// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage RV32I pipeline.
// Optional macro HAZARD_FORWARDING_EN enables EX operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      reg_writeE_i,
    input  logic                      reg_writeM_i,
    input  logic                      reg_writeW_i,
    input  logic                      result_srcE_i,
    input  logic                      pc_srcE_i,
    input  logic                      mem_reqM_i,
    input  logic                      mem_ack_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o,
    output logic                      mem_busy_o,
    output logic [CNT_WIDTH-1:0]      mem_stall_cnt_o
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 pending_flush_q;
    logic                 pending_flush_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic mem_stall;
    logic branch_flush;
    logic load_use;
    logic data_hazard;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    assign mem_stall = mem_reqM_i & ~mem_ack_i;
    assign branch_flush = (pc_srcE_i | pending_flush_q) & ~mem_stall;

    assign load_use = result_srcE_i && (rdE_i != '0) &&
                      ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

`ifdef HAZARD_FORWARDING_EN
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reg_writeM_i && (rdM_i != '0) && (rdM_i == rs1E_i))
            fwd_a = 2'b10;
        else if (reg_writeW_i && (rdW_i != '0) && (rdW_i == rs1E_i))
            fwd_a = 2'b01;
        if (reg_writeM_i && (rdM_i != '0) && (rdM_i == rs2E_i))
            fwd_b = 2'b10;
        else if (reg_writeW_i && (rdW_i != '0) && (rdW_i == rs2E_i))
            fwd_b = 2'b01;
    end

    assign data_hazard = load_use;
`else
    logic raw_e;
    logic raw_m;
    logic unused_fwd_inputs;

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;

    // Without forwarding, decode waits until the producer reaches W;
    // W needs no stall because the register file writes on the falling edge.
    assign raw_e = reg_writeE_i && (rdE_i != '0) &&
                   ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
    assign raw_m = reg_writeM_i && (rdM_i != '0) &&
                   ((rdM_i == rs1D_i) || (rdM_i == rs2D_i));

    assign data_hazard = load_use | raw_e | raw_m;
    assign unused_fwd_inputs = ^{rs1E_i, rs2E_i, rdW_i, reg_writeW_i};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mem_stall) state_d = S_WAIT;
            S_WAIT: if (mem_ack_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A branch seen during a memory stall is remembered until the stall ends.
    always_comb begin
        pending_flush_d = 1'b0;
        if (mem_stall)
            pending_flush_d = pending_flush_q | pc_srcE_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            pending_flush_q <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            if (mem_stall && (cnt_q != {CNT_WIDTH{1'b1}}))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        stallF_o        = 1'b0;
        stallD_o        = 1'b0;
        stallE_o        = 1'b0;
        stallM_o        = 1'b0;
        flushD_o        = 1'b0;
        flushE_o        = 1'b0;
        flushW_o        = 1'b0;
        forwardAE_o     = 2'b00;
        forwardBE_o     = 2'b00;
        mem_busy_o      = 1'b0;
        mem_stall_cnt_o = '0;
        if (rst_ni) begin
            forwardAE_o     = fwd_a;
            forwardBE_o     = fwd_b;
            mem_busy_o      = (state_q == S_WAIT);
            mem_stall_cnt_o = cnt_q;
            if (mem_stall) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else if (branch_flush) begin
                flushD_o = 1'b1;
                flushE_o = 1'b1;
            end else if (data_hazard) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                flushE_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [4:0] rs1D_i, rs2D_i, rs1E_i, rs2E_i;
    logic [4:0] rdE_i, rdM_i, rdW_i;
    logic       reg_writeE_i, reg_writeM_i, reg_writeW_i;
    logic       result_srcE_i, pc_srcE_i, mem_reqM_i, mem_ack_i;

    logic        stallF_o, stallD_o, stallE_o, stallM_o;
    logic        flushD_o, flushE_o, flushW_o;
    logic [1:0]  forwardAE_o, forwardBE_o;
    logic        mem_busy_o;
    logic [15:0] mem_stall_cnt_o;

    logic        s_stallF, s_stallD, s_stallE, s_stallM;
    logic        s_flushD, s_flushE, s_flushW;
    logic [1:0]  s_fwdA, s_fwdB;
    logic        s_busy;
    logic [3:0]  s_cnt;

    logic [6:0] ctl;
    assign ctl = {stallF_o, stallD_o, stallE_o, stallM_o,
                  flushD_o, flushE_o, flushW_o};

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
        .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
        .rdE_i(rdE_i), .rdM_i(rdM_i), .rdW_i(rdW_i),
        .reg_writeE_i(reg_writeE_i), .reg_writeM_i(reg_writeM_i),
        .reg_writeW_i(reg_writeW_i),
        .result_srcE_i(result_srcE_i), .pc_srcE_i(pc_srcE_i),
        .mem_reqM_i(mem_reqM_i), .mem_ack_i(mem_ack_i),
        .stallF_o(stallF_o), .stallD_o(stallD_o),
        .stallE_o(stallE_o), .stallM_o(stallM_o),
        .flushD_o(flushD_o), .flushE_o(flushE_o), .flushW_o(flushW_o),
        .forwardAE_o(forwardAE_o), .forwardBE_o(forwardBE_o),
        .mem_busy_o(mem_busy_o), .mem_stall_cnt_o(mem_stall_cnt_o)
    );

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_small (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1D_i(rs1D_i), .rs2D_i(rs2D_i),
        .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
        .rdE_i(rdE_i), .rdM_i(rdM_i), .rdW_i(rdW_i),
        .reg_writeE_i(reg_writeE_i), .reg_writeM_i(reg_writeM_i),
        .reg_writeW_i(reg_writeW_i),
        .result_srcE_i(result_srcE_i), .pc_srcE_i(pc_srcE_i),
        .mem_reqM_i(mem_reqM_i), .mem_ack_i(mem_ack_i),
        .stallF_o(s_stallF), .stallD_o(s_stallD),
        .stallE_o(s_stallE), .stallM_o(s_stallM),
        .flushD_o(s_flushD), .flushE_o(s_flushE), .flushW_o(s_flushW),
        .forwardAE_o(s_fwdA), .forwardBE_o(s_fwdB),
        .mem_busy_o(s_busy), .mem_stall_cnt_o(s_cnt)
    );

    task automatic clear_inputs();
        rs1D_i = 0; rs2D_i = 0; rs1E_i = 0; rs2E_i = 0;
        rdE_i = 0; rdM_i = 0; rdW_i = 0;
        reg_writeE_i = 0; reg_writeM_i = 0; reg_writeW_i = 0;
        result_srcE_i = 0; pc_srcE_i = 0;
        mem_reqM_i = 0; mem_ack_i = 0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        mem_reqM_i = 1'b1;
        #1;
        checks++;
        if (ctl !== 7'b0 || mem_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs ctl=%b busy=%b want 0", ctl, mem_busy_o);
        end
        checks++;
        if (mem_stall_cnt_o !== 16'd0 || forwardAE_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_cnt cnt=%0d fwdA=%b want 0", mem_stall_cnt_o, forwardAE_o);
        end
        next_cycle();
        clear_inputs();
        rst_ni = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctl !== 7'b0 || mem_busy_o !== 1'b0 || mem_stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle ctl=%b busy=%b cnt=%0d want 0", ctl, mem_busy_o, mem_stall_cnt_o);
        end
    endtask

    task automatic test_forwarding();
        next_cycle();
        clear_inputs();
`ifdef HAZARD_FORWARDING_EN
        reg_writeM_i = 1; rdM_i = 5;
        reg_writeW_i = 1; rdW_i = 5;
        rs1E_i = 5; rs2E_i = 9;
        #1;
        checks++;
        if (forwardAE_o !== 2'b10 || forwardBE_o !== 2'b00) begin
            errors++;
            $display("FAIL fwd_m_prio A=%b B=%b want 10 00", forwardAE_o, forwardBE_o);
        end
        rdM_i = 0;
        #1;
        checks++;
        if (forwardAE_o !== 2'b01) begin
            errors++;
            $display("FAIL fwd_w A=%b want 01", forwardAE_o);
        end
        rdM_i = 9; rdW_i = 0; rs1E_i = 0;
        #1;
        checks++;
        if (forwardAE_o !== 2'b00 || forwardBE_o !== 2'b10) begin
            errors++;
            $display("FAIL fwd_b A=%b B=%b want 00 10", forwardAE_o, forwardBE_o);
        end
        reg_writeM_i = 0;
        #1;
        checks++;
        if (forwardBE_o !== 2'b00 || ctl !== 7'b0) begin
            errors++;
            $display("FAIL fwd_nowrite B=%b ctl=%b want 00 0", forwardBE_o, ctl);
        end
`else
        reg_writeM_i = 1; rdM_i = 5;
        reg_writeW_i = 1; rdW_i = 5;
        rs1E_i = 5; rs1D_i = 5;
        #1;
        checks++;
        if (forwardAE_o !== 2'b00 || ctl !== 7'b1100010) begin
            errors++;
            $display("FAIL raw_m_stall fwdA=%b ctl=%b want 00 1100010", forwardAE_o, ctl);
        end
        rdM_i = 0;
        #1;
        checks++;
        if (forwardAE_o !== 2'b00 || ctl !== 7'b0) begin
            errors++;
            $display("FAIL raw_w_none fwdA=%b ctl=%b want 00 0", forwardAE_o, ctl);
        end
        reg_writeE_i = 1; rdE_i = 6; rs2D_i = 6;
        #1;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++;
            $display("FAIL raw_e_stall ctl=%b want 1100010", ctl);
        end
        reg_writeE_i = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL raw_nowrite ctl=%b want 0", ctl);
        end
`endif
    endtask

    task automatic test_load_use();
        next_cycle();
        clear_inputs();
        result_srcE_i = 1; reg_writeE_i = 1; rdE_i = 7; rs2D_i = 7;
        #1;
        checks++;
        if (ctl !== 7'b1100010) begin
            errors++;
            $display("FAIL load_use ctl=%b want 1100010", ctl);
        end
        next_cycle();
        result_srcE_i = 0; reg_writeE_i = 0; rdE_i = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL load_use_one_bubble ctl=%b want 0", ctl);
        end
        result_srcE_i = 1; reg_writeE_i = 1; rs2D_i = 0;
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL load_use_x0 ctl=%b want 0", ctl);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        pc_srcE_i = 1;
        result_srcE_i = 1; reg_writeE_i = 1; rdE_i = 3; rs1D_i = 3;
        #1;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++;
            $display("FAIL branch_over_loaduse ctl=%b want 0000110", ctl);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL branch_done ctl=%b want 0", ctl);
        end
    endtask

    task automatic test_mem_wait();
        logic [15:0] base;
        next_cycle();
        clear_inputs();
        base = mem_stall_cnt_o;
        mem_reqM_i = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++;
            if (ctl !== 7'b1111001 || mem_busy_o !== (c > 1)) begin
                errors++;
                $display("FAIL mem_wait_c%0d ctl=%b busy=%b want 1111001 %b", c, ctl, mem_busy_o, c > 1);
            end
            checks++;
            if (mem_stall_cnt_o !== base + 16'(c - 1)) begin
                errors++;
                $display("FAIL mem_cnt_c%0d cnt=%0d want %0d", c, mem_stall_cnt_o, base + 16'(c - 1));
            end
            next_cycle();
        end
        mem_ack_i = 1;
        #1;
        checks++;
        if (ctl !== 7'b0 || mem_busy_o !== 1'b1 || mem_stall_cnt_o !== base + 16'd3) begin
            errors++;
            $display("FAIL mem_ack ctl=%b busy=%b cnt=%0d want 0 1 %0d", ctl, mem_busy_o, mem_stall_cnt_o, base + 16'd3);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (mem_busy_o !== 1'b0 || mem_stall_cnt_o !== base + 16'd3) begin
            errors++;
            $display("FAIL mem_idle busy=%b cnt=%0d want 0 %0d", mem_busy_o, mem_stall_cnt_o, base + 16'd3);
        end
        mem_reqM_i = 1; mem_ack_i = 1;
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (mem_busy_o !== 1'b0 || mem_stall_cnt_o !== base + 16'd3) begin
            errors++;
            $display("FAIL mem_zero_wait busy=%b cnt=%0d want 0 %0d", mem_busy_o, mem_stall_cnt_o, base + 16'd3);
        end
    endtask

    task automatic test_branch_during_wait();
        next_cycle();
        clear_inputs();
        mem_reqM_i = 1; pc_srcE_i = 1;
        #1;
        checks++;
        if (ctl !== 7'b1111001) begin
            errors++;
            $display("FAIL bw_c1 ctl=%b want 1111001", ctl);
        end
        next_cycle();
        pc_srcE_i = 0;
        #1;
        checks++;
        if (ctl !== 7'b1111001) begin
            errors++;
            $display("FAIL bw_c2 ctl=%b want 1111001", ctl);
        end
        next_cycle();
        mem_ack_i = 1;
        #1;
        checks++;
        if (ctl !== 7'b0000110) begin
            errors++;
            $display("FAIL bw_ack ctl=%b want 0000110", ctl);
        end
        next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 7'b0) begin
            errors++;
            $display("FAIL bw_cleared ctl=%b want 0", ctl);
        end
    endtask

    task automatic test_reset_mid_wait();
        next_cycle();
        clear_inputs();
        mem_reqM_i = 1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if (mem_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL rmw_busy busy=%b want 1", mem_busy_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ctl !== 7'b0 || mem_busy_o !== 1'b0 || mem_stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL rmw_reset ctl=%b busy=%b cnt=%0d want 0 0 0", ctl, mem_busy_o, mem_stall_cnt_o);
        end
        next_cycle();
        clear_inputs();
        rst_ni = 1'b1;
        #1;
        checks++;
        if (mem_busy_o !== 1'b0 || mem_stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL rmw_after busy=%b cnt=%0d want 0 0", mem_busy_o, mem_stall_cnt_o);
        end
    endtask

    task automatic test_saturation();
        next_cycle();
        clear_inputs();
        mem_reqM_i = 1;
        repeat (15) next_cycle();
        #1;
        checks++;
        if (s_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach cnt=%0d want 15", s_cnt);
        end
        repeat (5) next_cycle();
        clear_inputs();
        #1;
        checks++;
        if (s_cnt !== 4'd15 || mem_stall_cnt_o !== 16'd20) begin
            errors++;
            $display("FAIL sat_hold small=%0d big=%0d want 15 20", s_cnt, mem_stall_cnt_o);
        end
        checks++;
        if (s_busy !== 1'b1 || s_stallM !== 1'b0) begin
            errors++;
            $display("FAIL sat_ack small busy=%b stallM=%b want 1 0", s_busy, s_stallM);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_branch_during_wait();
        test_reset_mid_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and stall controller for the five-stage RV32I pipeline. It drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the forwarding-mux selects in execute. It also sequences multi-cycle data-memory accesses with a req/ack wait state machine. It sits beside the datapath and takes register indices and control bits from each pipeline stage.

## Interface
- `REG_ADDR_WIDTH`, default 5: register index width.
- `CNT_WIDTH`, default 16: width of the memory-stall performance counter.

Ports:
- `clk_i` in, 1: clock; all state updates on the rising edge.
- `rst_ni` in, 1: reset, asynchronous, active-low.
- `rs1D_i`, `rs2D_i` in, REG_ADDR_WIDTH: source registers in decode.
- `rs1E_i`, `rs2E_i` in, REG_ADDR_WIDTH: source registers in execute.
- `rdE_i`, `rdM_i`, `rdW_i` in, REG_ADDR_WIDTH: destination registers in E, M and W.
- `reg_writeE_i`, `reg_writeM_i`, `reg_writeW_i` in, 1: register-write enables per stage.
- `result_srcE_i` in, 1: the instruction in E is a load.
- `pc_srcE_i` in, 1: branch or jump taken, resolved in E.
- `mem_reqM_i` in, 1: the instruction in M accesses data memory.
- `mem_ack_i` in, 1: data memory has completed the access.
- `stallF_o`, `stallD_o`, `stallE_o`, `stallM_o` out, 1: hold the corresponding pipeline register.
- `flushD_o`, `flushE_o`, `flushW_o` out, 1: load a bubble into D/E/W.
- `forwardAE_o`, `forwardBE_o` out, 2: operand select. 00 = register file, 10 = ALU result in M, 01 = result in W.
- `mem_busy_o` out, 1: the FSM is in WAIT.
- `mem_stall_cnt_o` out, CNT_WIDTH: saturating count of memory-wait cycles.

## Operation
- FSM states are IDLE and WAIT.
  - IDLE → WAIT when `mem_reqM_i` is high and `mem_ack_i` is low.
  - WAIT → IDLE when `mem_ack_i` is high.
  - A zero-wait access (req and ack in the same cycle) stays in IDLE.
- Memory stall is `mem_stall = mem_reqM_i & ~mem_ack_i` in either state.
  - It asserts `stallF_o`, `stallD_o`, `stallE_o`, `stallM_o` and `flushW_o`.
  - It overrides every other stall or flush.
- Load-use stall: `result_srcE_i` high, `rdE_i` ≠ 0, and `rdE_i` equals `rs1D_i` or `rs2D_i`.
  - It asserts `stallF_o`, `stallD_o` and `flushE_o`.
- Branch flush: `pc_srcE_i` asserts `flushD_o` and `flushE_o`.
  - If it coincides with a memory stall, it sets `pending_flush` instead.
  - `pending_flush` is issued on the first non-memory-stall cycle and then cleared.
  - A branch flush takes priority over a load-use stall in the same cycle.
- Forwarding for each operand (shown for rs1E; rs2E is identical):
  - 10 if `reg_writeM_i` is high, `rdM_i` ≠ 0 and `rdM_i` = `rs1E_i`.
  - Otherwise 01 if the same test holds for W.
  - Otherwise 00.
  - M takes priority over W.
  - Register x0 is never forwarded and never causes a hazard.
- The register file writes on the falling edge, so a W-stage producer never causes a decode hazard.
- `mem_stall_cnt_o` increments on every cycle with `mem_stall` high and saturates at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from the inputs and registered state, valid in the same cycle.
- While `rst_ni` is low, all outputs are 0, the FSM is in IDLE, `pending_flush` is 0 and the counter is 0. Reset is effective immediately, including mid-WAIT.
- `mem_busy_o` is registered and goes high the cycle after the entry condition.
- A pending flush appears in the cycle in which `mem_ack_i` is seen high, if no new memory stall exists in that cycle.
- A load-use hazard costs exactly 1 bubble. A branch costs 2 flushed slots.

## Configuration
- `HAZARD_FORWARDING_EN` defined: forwarding operates as described above.
- `HAZARD_FORWARDING_EN` undefined:
  - `forwardAE_o` and `forwardBE_o` are tied to 00.
  - Any decode source matching a writing `rdE_i` or `rdM_i` (≠ 0) causes a RAW stall: `stallF_o`, `stallD_o` and `flushE_o`, held until the producer reaches W.
  - Memory and branch behaviour are unchanged.

## Test plan
- Forwarding: `rdM_i`=5 with `reg_writeM_i`=1, `rdW_i`=5 with `reg_writeW_i`=1, `rs1E_i`=5 → `forwardAE_o`=10. Repeat with `rdM_i`=0 → `forwardAE_o`=01.
- Load-use: `result_srcE_i`=1, `rdE_i`=7, `rs2D_i`=7 → one cycle of `stallF_o`=`stallD_o`=`flushE_o`=1. The same case with `rdE_i`=0 → all outputs 0.
- Memory wait: `mem_reqM_i`=1 with ack low for 3 cycles, then ack high.
  - `stallF_o`..`stallM_o` and `flushW_o` are high for 3 cycles.
  - `mem_busy_o` is high for cycles 2–4.
  - `mem_stall_cnt_o`=3.
- Branch during memory wait: `pc_srcE_i`=1 in wait cycle 1 → `flushD_o`=`flushE_o`=1 only in the ack cycle.
- Reset: deassert `rst_ni` mid-WAIT → all outputs 0 immediately, state IDLE, counter 0.
- Counter saturation with `CNT_WIDTH`=4: 20 memory-wait cycles → `mem_stall_cnt_o`=15.
